// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants and helpers for the parametrised VGA/VESA raster timing
//   generator (vga_timing_gen) and its per-axis counter (vga_axis_counter).
//   Provides the default 800x600@60 timing set, plus 640x480@60 and
//   1024x768@60 sets, and a helper that sums one axis into its total period.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // One axis (horizontal or vertical) of a display mode.
  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } axis_mode_t;

  // A complete display mode: horizontal axis in pixels, vertical in lines.
  typedef struct packed {
    axis_mode_t h;
    axis_mode_t v;
  } vga_mode_t;

  // 800x600@60 (40 MHz pixel clock), the generator's default.
  localparam vga_mode_t MODE_800X600_60 = '{
    h: '{active: 16'd800,  fp: 16'd40, sync: 16'd128, bp: 16'd88},
    v: '{active: 16'd600,  fp: 16'd1,  sync: 16'd4,   bp: 16'd23}
  };

  // 640x480@60 (25.175 MHz pixel clock), negative syncs in the VESA table.
  localparam vga_mode_t MODE_640X480_60 = '{
    h: '{active: 16'd640,  fp: 16'd16, sync: 16'd96,  bp: 16'd48},
    v: '{active: 16'd480,  fp: 16'd10, sync: 16'd2,   bp: 16'd33}
  };

  // 1024x768@60 (65 MHz pixel clock), negative syncs in the VESA table.
  localparam vga_mode_t MODE_1024X768_60 = '{
    h: '{active: 16'd1024, fp: 16'd24, sync: 16'd136, bp: 16'd160},
    v: '{active: 16'd768,  fp: 16'd3,  sync: 16'd6,   bp: 16'd29}
  };

  // Full period of one axis: visible region plus all blanking parts.
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   One raster axis: a counter that wraps at ACTIVE+FP+SYNC+BP-1, with the
//   sync and blank flags registered from the next count so they always line
//   up with the count presented on the same cycle.
// Ports
//   clk        in   pixel clock
//   rst        in   synchronous, active-high reset (count=0, sync idle, blank=0)
//   adv        in   advance the count by one on this clock
//   count      out  current position on this axis
//   wrap       out  combinational: adv is high and count is at its last value
//   sync       out  registered sync, active level SYNC_POL
//   blank      out  registered, 1 when count >= ACTIVE
//   blank_nxt  out  combinational blank decode of the next count
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   CNT_W    = 11,
  parameter int   ACTIVE   = 800,
  parameter int   FP       = 40,
  parameter int   SYNC     = 128,
  parameter int   BP       = 88,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             blank,
  output logic             blank_nxt
);

  localparam int TOTAL = int'(axis_total(ACTIVE, FP, SYNC, BP));

  // All thresholds are strictly below TOTAL (every porch is non-zero), so
  // they fit in CNT_W bits whenever TOTAL <= 2**CNT_W.
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] count_nxt;

  function automatic logic sync_level(input logic [CNT_W-1:0] c);
    return ((c >= SYNC_BEG) && (c < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  endfunction

  // Next-count stage: wrap/advance and decode of the position about to load.
  always_comb begin
    wrap      = adv && (count == LAST);
    count_nxt = count;
    if (adv) begin
      count_nxt = (count == LAST) ? '0 : count + CNT_W'(1);
    end
    blank_nxt = (count_nxt >= ACT_END);
  end

  // Register stage: count and its flags load together, so there is no skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      sync  <= ~SYNC_POL;
      blank <= 1'b0;
    end else begin
      count <= count_nxt;
      sync  <= sync_level(count_nxt);
      blank <= blank_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA/VESA raster timing generator. Produces H/V counters,
//   sync, blank, data-enable, line/frame strobes and a completed-frame count.
//   Every output is registered and describes the hcount/vcount presented on
//   the same cycle. Counters advance only on clocks where ce is high.
//
// Optional feature (macro VGA_TIMING_LINE_IRQ_EN):
//   adds input irq_line and output line_irq, a 1-clk strobe in the cycle
//   where vcount becomes irq_line with hcount==0. irq_line is captured at
//   reset and at each frame start, so a change applies from the next frame.
//   Without the macro the ports and comparator are not built.
//
// Ports
//   clk          in   pixel clock
//   rst          in   synchronous, active-high reset; overrides ce
//   ce           in   pixel enable
//   irq_line     in   (macro only) line number that raises line_irq
//   line_irq     out  (macro only) line interrupt strobe
//   hcount       out  horizontal position
//   vcount       out  vertical position
//   hsync        out  horizontal sync, active level HS_POL
//   vsync        out  vertical sync, active level VS_POL
//   hblnk        out  1 when hcount >= H_ACTIVE
//   vblnk        out  1 when vcount >= V_ACTIVE
//   de           out  ~hblnk & ~vblnk
//   line_start   out  1-clk strobe: hcount just wrapped to 0
//   frame_start  out  1-clk strobe: (hcount,vcount) just wrapped to (0,0)
//   frame_cnt    out  completed frames, wraps modulo 2**FRAME_W
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CNT_W    = 11,
  parameter int   H_ACTIVE = int'(MODE_800X600_60.h.active),
  parameter int   H_FP     = int'(MODE_800X600_60.h.fp),
  parameter int   H_SYNC   = int'(MODE_800X600_60.h.sync),
  parameter int   H_BP     = int'(MODE_800X600_60.h.bp),
  parameter int   V_ACTIVE = int'(MODE_800X600_60.v.active),
  parameter int   V_FP     = int'(MODE_800X600_60.v.fp),
  parameter int   V_SYNC   = int'(MODE_800X600_60.v.sync),
  parameter int   V_BP     = int'(MODE_800X600_60.v.bp),
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [CNT_W-1:0]   irq_line,
  output logic               line_irq,
`endif
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = int'(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int V_TOTAL = int'(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

  // Elaboration-time guards on the mode geometry.
  if (H_TOTAL > 2**CNT_W) begin : g_chk_htotal
    $error("vga_timing_gen: H_TOTAL=%0d does not fit CNT_W=%0d", H_TOTAL, CNT_W);
  end
  if (V_TOTAL > 2**CNT_W) begin : g_chk_vtotal
    $error("vga_timing_gen: V_TOTAL=%0d does not fit CNT_W=%0d", V_TOTAL, CNT_W);
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_chk_zero
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end

  logic h_wrap;
  logic v_wrap;
  logic h_blank_nxt;
  logic v_blank_nxt;
  logic frame_evt;

  vga_axis_counter #(
    .CNT_W    (CNT_W),
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (HS_POL)
  ) u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .adv       (ce),
    .count     (hcount),
    .wrap      (h_wrap),
    .sync      (hsync),
    .blank     (hblnk),
    .blank_nxt (h_blank_nxt)
  );

  // The vertical axis steps once per completed line.
  vga_axis_counter #(
    .CNT_W    (CNT_W),
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (VS_POL)
  ) u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .adv       (h_wrap),
    .count     (vcount),
    .wrap      (v_wrap),
    .sync      (vsync),
    .blank     (vblnk),
    .blank_nxt (v_blank_nxt)
  );

  // h_wrap already carries ce, so strobes stay low while ce is low.
  assign frame_evt = h_wrap && v_wrap;

  // Register stage: strobes, de and frame count load alongside the counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      de          <= 1'b1;
    end else begin
      line_start  <= h_wrap;
      frame_start <= frame_evt;
      de          <= ~h_blank_nxt & ~v_blank_nxt;
      if (frame_evt) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [CNT_W-1:0] irq_sel;
  logic             irq_hit;

  // The next vcount is 0 on a frame wrap, otherwise vcount+1. Line numbers
  // at or beyond V_TOTAL never match because vcount never reaches them.
  always_comb begin
    irq_hit = 1'b0;
    if (h_wrap) begin
      irq_hit = v_wrap ? (irq_sel == '0) : ((vcount + CNT_W'(1)) == irq_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_sel  <= irq_line;
      line_irq <= 1'b0;
    end else begin
      if (frame_evt) begin
        irq_sel <= irq_line;
      end
      line_irq <= irq_hit;
    end
  end
`endif

endmodule
